// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder: FSM encoding, padding constants
// and the FIFO entry layout.
package sha1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } pad_state_e;

  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned FIFO_DEPTH  = 2;

  typedef struct packed {
    logic        last_blk;
    logic        last_msg;
    logic [31:0] word;
  } fifo_entry_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // 16 words per block; one extra block whenever the 0x80 byte plus 8 length bytes overflow.
  function automatic logic [31:0] total_words(input logic [31:0] size);
    return 32'(((((33'(size) + 33'd8) >> $clog2(BLOCK_BYTES)) + 33'd1) << 4));
  endfunction

endpackage

// File: rtl/sha1_word_fifo.sv
// Two-entry output buffer between the padding datapath and the word stream;
// the head entry stays put until it is popped.
module sha1_word_fifo
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  fifo_entry_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output fifo_entry_t out_data,
  output logic [1:0]  count
);

  fifo_entry_t mem [FIFO_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset too, so word_out reads zero straight out of reset;
      // a larger buffer would leave its data array unreset and rely on the valid count.
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: reads a message from a synchronous RAM port and streams it
// as padded big-endian 32-bit schedule words, 16 per 512-bit block.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_pad,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic              port_A_we,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last_blk,
  output logic              word_last_msg,
  output logic              busy,
  output logic              done
);

  pad_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       size_q;
  logic [31:0]       total_q;
  logic [31:0]       gen_idx;
  logic [31:0]       rd_idx;
  logic              rd_valid;
  logic              issue;
  logic              credit_ok;
  logic [29:0]       full_words;
  logic [ADDR_W-3:0] addr_word;
  logic [31:0]       mem_word;
  fifo_entry_t       push_entry;
  fifo_entry_t       pop_entry;
  logic              fifo_in_ready;
  logic              fifo_out_valid;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic              unused_sigs;

  // Credit accounting below guarantees a free slot for every in-flight read, so in_ready is informational.
  assign unused_sigs    = ^{message_addr[31:ADDR_W], fifo_in_ready};
  assign port_A_clk     = clk;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'h0;

  assign full_words  = size_q[31:2];
  // Pure padding words park the address on the last message word instead of running past it.
  assign addr_word   = (gen_idx > {2'b00, full_words}) ? full_words[ADDR_W-3:0]
                                                       : gen_idx[ADDR_W-3:0];
  assign port_A_addr = base_q + {addr_word, 2'b00};

  assign fifo_pop  = fifo_out_valid & word_ready;
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, rd_valid}) <= (3'd1 + {2'b00, fifo_pop});
  assign issue     = (state_q == ST_RUN) && credit_ok;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_pad) state_d = ST_RUN;
      end
      ST_RUN:   if (issue && gen_idx == total_q - 32'd1) state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_valid && fifo_count == 2'd0) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      size_q   <= '0;
      total_q  <= '0;
      gen_idx  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_pad) begin
        base_q  <= message_addr[ADDR_W-1:0];
        size_q  <= message_size;
        total_q <= total_words(message_size);
        gen_idx <= '0;
      end else if (issue) begin
        gen_idx <= gen_idx + 32'd1;
      end
      rd_valid <= issue;
      if (issue) rd_idx <= gen_idx;
    end
  end

  assign mem_word = bswap32(port_A_data_out);

  always_comb begin
    push_entry          = '0;
    push_entry.last_blk = &rd_idx[3:0];
    push_entry.last_msg = (rd_idx == total_q - 32'd1);
    if (rd_idx < {2'b00, full_words}) begin
      push_entry.word = mem_word;
    end else if (rd_idx == {2'b00, full_words}) begin
      case (size_q[1:0])
        2'd0:    push_entry.word = {PAD_BYTE, 24'h0};
        2'd1:    push_entry.word = {mem_word[31:24], PAD_BYTE, 16'h0};
        2'd2:    push_entry.word = {mem_word[31:16], PAD_BYTE, 8'h0};
        default: push_entry.word = {mem_word[31:8], PAD_BYTE};
      endcase
    end else if (rd_idx == total_q - 32'd2) begin
      push_entry.word = {29'h0, size_q[31:29]};
    end else if (rd_idx == total_q - 32'd1) begin
      push_entry.word = {size_q[28:0], 3'b000};
    end
  end

  sha1_word_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (push_entry),
    .out_valid (fifo_out_valid),
    .out_ready (word_ready),
    .out_data  (pop_entry),
    .count     (fifo_count)
  );

  assign word_out      = pop_entry.word;
  assign word_valid    = fifo_out_valid;
  assign word_last_blk = pop_entry.last_blk;
  assign word_last_msg = pop_entry.last_msg;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: synchronous RAM model, byte-level padding
// reference, hand-computed spot values and handshake/stall checks.
module tb_sha1_msg_padder;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_pad;
  logic [31:0]       message_addr;
  logic [31:0]       message_size;
  logic              port_A_clk;
  logic              port_A_we;
  logic [ADDR_W-1:0] port_A_addr;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;
  logic [31:0]       word_out;
  logic              word_valid;
  logic              word_ready;
  logic              word_last_blk;
  logic              word_last_msg;
  logic              busy;
  logic              done;

  logic [31:0] mem [256];
  logic [33:0] cap_q [$];
  int          done_cnt;
  int          first_valid;
  int          first_xfer;
  int          last_xfer;
  int          n_checks;
  int          n_errors;

  always #5 clk = ~clk;

  always @(posedge clk) port_A_data_out <= mem[port_A_addr[9:2]];

  sha1_msg_padder #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_pad       (start_pad),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .port_A_clk      (port_A_clk),
    .port_A_we       (port_A_we),
    .port_A_addr     (port_A_addr),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .word_last_blk   (word_last_blk),
    .word_last_msg   (word_last_msg),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference built byte by byte: message, 0x80, zeros, 64-bit big-endian bit length.
  function automatic logic [31:0] model_word(input logic [31:0] addr, input int size, input int k);
    int          total_b;
    int          j;
    logic [63:0] len_bits;
    logic [31:0] w;
    logic [15:0] a;
    total_b  = 64 * ((size + 8) / 64 + 1);
    len_bits = 64'(size) << 3;
    w        = '0;
    for (int b = 0; b < 4; b++) begin
      j = 4 * k + b;
      a = addr[15:0] + 16'(j);
      w = w << 8;
      if (j < size)              w[7:0] = mem_byte(a);
      else if (j == size)        w[7:0] = 8'h80;
      else if (j >= total_b - 8) w[7:0] = len_bits[8*(total_b-1-j) +: 8];
    end
    return w;
  endfunction

  task automatic run_msg(input logic [31:0] addr, input logic [31:0] size, input bit toggle,
                         input int abort_at, input bit restart);
    logic [31:0] prev_word;
    logic        prev_stall;
    bit          restarted;
    int          tail;
    cap_q.delete();
    done_cnt    = 0;
    first_valid = -1;
    first_xfer  = -1;
    last_xfer   = -1;
    prev_stall  = 1'b0;
    prev_word   = '0;
    restarted   = 1'b0;
    tail        = 0;
    @(posedge clk); #1;
    message_addr = addr;
    message_size = size;
    start_pad    = 1'b1;
    word_ready   = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      start_pad = 1'b0;
      if (cyc == 0) begin
        message_addr = 32'hDEAD_BEEF;
        message_size = 32'd999;
      end
      word_ready = toggle ? ~word_ready : 1'b1;
      #1;
      if (prev_stall) begin
        check("stall_valid", word_valid, 1);
        check("stall_word", word_out, prev_word);
      end
      if (word_valid && first_valid < 0) first_valid = cyc;
      if (word_valid && word_ready) begin
        cap_q.push_back({word_last_blk, word_last_msg, word_out});
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      prev_stall = word_valid && !word_ready;
      prev_word  = word_out;
      if (done) done_cnt++;
      if (done_cnt > 0) tail++;
      if (tail > 4) break;
      if (restart && !restarted && cap_q.size() == 5) begin
        restarted    = 1'b1;
        start_pad    = 1'b1;
        message_addr = 32'h0;
        message_size = 32'd100;
      end
      if (abort_at >= 0 && cap_q.size() == abort_at) begin
        check("abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_outs", {word_out, word_valid, word_last_blk, word_last_msg, busy, done, port_A_addr}, '0);
        @(posedge clk); #1;
        check("abort_hold", {word_out, word_valid, word_last_blk, word_last_msg, busy, done, port_A_addr}, '0);
        reset = 1'b0;
        return;
      end
    end
  endtask

  task automatic verify(input string name, input logic [31:0] addr, input logic [31:0] size,
                        input bit full_rate);
    int total;
    total = 16 * ((int'(size) + 8) / 64 + 1);
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_count"}, cap_q.size(), total);
    check({name, "_first_valid_le3"}, (first_valid >= 0 && first_valid <= 3), 1);
    if (full_rate) check({name, "_rate"}, last_xfer - first_xfer + 1, total);
    for (int k = 0; k < cap_q.size() && k < total; k++) begin
      check($sformatf("%s_w%0d", name, k), cap_q[k][31:0], model_word(addr, int'(size), k));
      check($sformatf("%s_f%0d", name, k), cap_q[k][33:32], {k % 16 == 15, k == total - 1});
    end
  endtask

  task automatic check_abc(input string name);
    check({name, "_w0"}, cap_q[0][31:0], 32'h6162_6380);
    check({name, "_w14"}, cap_q[14][31:0], 32'h0);
    check({name, "_w15"}, cap_q[15], {2'b11, 32'h0000_0018});
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    start_pad    = 1'b0;
    message_addr = '0;
    message_size = '0;
    word_ready   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    mem[128] = 32'h0063_6261;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {word_out, word_valid, word_last_blk, word_last_msg, busy, done}, '0);
    check("rst_addr", port_A_addr, 0);
    check("tie_off", {port_A_we, port_A_data_in}, 0);
    check("port_clk", port_A_clk, clk);
    reset = 1'b0;

    run_msg(32'h200, 32'd3, 1'b0, -1, 1'b0);
    verify("abc", 32'h200, 32'd3, 1'b1);
    check_abc("abc");

    run_msg(32'h0, 32'd0, 1'b0, -1, 1'b0);
    verify("empty", 32'h0, 32'd0, 1'b1);
    check("empty_w0", cap_q[0][31:0], 32'h8000_0000);

    run_msg(32'h0, 32'd56, 1'b0, -1, 1'b0);
    verify("s56", 32'h0, 32'd56, 1'b1);
    check("s56_w14", cap_q[14][31:0], 32'h8000_0000);
    check("s56_w15_blk", cap_q[15][33], 1);
    check("s56_w31", cap_q[31], {2'b11, 32'h0000_01C0});

    run_msg(32'h0, 32'd64, 1'b0, -1, 1'b0);
    verify("s64", 32'h0, 32'd64, 1'b1);
    check("s64_w0", cap_q[0][31:0], 32'h0001_0203);
    check("s64_w16", cap_q[16][31:0], 32'h8000_0000);
    check("s64_w31", cap_q[31][31:0], 32'h0000_0200);

    run_msg(32'h0, 32'd64, 1'b1, -1, 1'b0);
    verify("s64_tog", 32'h0, 32'd64, 1'b0);
    check("s64_tog_w16", cap_q[16][31:0], 32'h8000_0000);

    run_msg(32'h80, 32'd64, 1'b0, 7, 1'b0);
    run_msg(32'h200, 32'd3, 1'b0, -1, 1'b0);
    verify("post_rst", 32'h200, 32'd3, 1'b1);
    check_abc("post_rst");

    run_msg(32'h40, 32'd20, 1'b0, -1, 1'b1);
    verify("restart", 32'h40, 32'd20, 1'b1);

    run_msg(32'hFFFC, 32'd8, 1'b0, -1, 1'b0);
    verify("wrap", 32'hFFFC, 32'd8, 1'b1);
    check("wrap_w0", cap_q[0][31:0], 32'hFCFD_FEFF);
    check("wrap_w1", cap_q[1][31:0], 32'h0001_0203);
    check("wrap_w2", cap_q[2][31:0], 32'h8000_0000);
    check("wrap_w15", cap_q[15][31:0], 32'h0000_0040);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
